instruction_cache: RTL and testbench



---
 rtl/instruction_cache_if.sv | 23 ++
 rtl/instruction_cache.sv | 97 +++++++++
 tb/tb_instruction_cache.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// CPU fetch port and instruction-memory block port of the instruction cache.
`timescale 1ns/1ps
interface instruction_cache_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           instruction;
  logic                  busywait;
  logic                  mem_read;
  logic [ADDR_WIDTH-5:0] mem_address;
  logic [127:0]          mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path,
// 4-word block refill from slow memory through an IDLE/MEM_READ/UPDATE FSM.
`timescale 1ns/1ps
module instruction_cache #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned INDEX_BITS = 3
) (
  input logic                 CLK,
  input logic                 RESET,
  instruction_cache_if.slave  bus
);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;
  localparam int unsigned N_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

  state_e                 state_q, state_d;
  logic [N_BLOCKS-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0]    tag_q  [N_BLOCKS];
  logic [3:0][31:0]       data_q [N_BLOCKS];
  logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
  logic [3:0][31:0]       fill_q, fill_d;
  logic                   mem_read_q, mem_read_d;

  logic [TAG_BITS-1:0]    cur_tag_c;
  logic [INDEX_BITS-1:0]  cur_idx_c;
  logic [1:0]             offset_c;
  logic                   hit_c;
  logic                   unused_addr_c;

  assign cur_tag_c     = bus.address[ADDR_WIDTH-1 -: TAG_BITS];
  assign cur_idx_c     = bus.address[4 +: INDEX_BITS];
  assign offset_c      = bus.address[3:2];
  assign unused_addr_c = ^bus.address[1:0];
  assign hit_c         = valid_q[cur_idx_c] && (tag_q[cur_idx_c] == cur_tag_c);

  // Outputs forced quiet while reset is held, even mid-refill.
  assign bus.instruction = RESET ? 32'h0 : data_q[cur_idx_c][offset_c];
  assign bus.busywait    = !RESET && ((state_q != IDLE) || !hit_c);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = {miss_tag_q, miss_idx_q};

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    fill_d     = fill_q;
    case (state_q)
      IDLE: begin
        if (!hit_c) begin
          miss_tag_d = cur_tag_c;
          miss_idx_d = cur_idx_c;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!bus.mem_busywait) begin
          fill_d  = bus.mem_readdata;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        valid_d[miss_idx_q] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_read_d = (state_d == MEM_READ);
  end

  // Miss/fill holding registers are only loaded outside reset, so a miss
  // coinciding with reset latches nothing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_read_q <= mem_read_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      fill_q     <= fill_d;
    end
  end

  // Tag/data storage is not reset; an aborted refill never reaches it.
  always_ff @(posedge CLK) begin
    if (!RESET && (state_q == UPDATE)) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= fill_q;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random
// fetches checked against a valid/tag table model and a latency-driven memory.
`timescale 1ns/1ps
module tb_instruction_cache;
  logic CLK;
  logic RESET;

  instruction_cache_if #(.ADDR_WIDTH(10)) bif ();

  instruction_cache #(.ADDR_WIDTH(10), .INDEX_BITS(3)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Backing memory: 64 blocks of 128 bits, fixed latency per access.
  logic [127:0] mem_blk [64];
  int unsigned  lat;
  int unsigned  cnt;

  always @(posedge CLK) begin
    if (RESET || !bif.mem_read) cnt <= 0;
    else                        cnt <= cnt + 1;
  end
  assign bif.mem_busywait = bif.mem_read && (cnt < lat);
  assign bif.mem_readdata = mem_blk[bif.mem_address];

  // Reference: which block each set holds.
  bit ref_valid [8];
  int ref_tag   [8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_hit(input logic [9:0] a);
    int idx;
    idx = int'(a[6:4]);
    return ref_valid[idx] && (ref_tag[idx] == int'(a[9:7]));
  endfunction

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    logic [127:0] blk;
    int w;
    blk = mem_blk[a[9:4]];
    w   = int'(a[3:2]);
    return blk[w*32 +: 32];
  endfunction

  task automatic install(input logic [9:0] a);
    ref_valid[int'(a[6:4])] = 1'b1;
    ref_tag[int'(a[6:4])]   = int'(a[9:7]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  // Observe one access whose address was driven just after the last edge.
  task automatic collect(input logic [9:0] a);
    bit miss;
    int n, rd, hold_bad;
    logic [5:0] ma;
    miss = !is_hit(a);
    n = 0; rd = 0; hold_bad = 0; ma = '0;
    @(negedge CLK);
    check("first_busywait", bif.busywait, miss);
    check("idle_no_read", bif.mem_read, 1'b0);
    while (bif.busywait && n < 64) begin
      if (bif.mem_read) begin
        if (rd == 0) ma = bif.mem_address;
        else if (bif.mem_address != ma) hold_bad++;
        rd++;
      end
      n++;
      @(negedge CLK);
    end
    check("busy_cycles", n, miss ? lat + 3 : 0);
    check("read_cycles", rd, miss ? lat + 1 : 0);
    if (miss) begin
      check("mem_address", ma, a[9:4]);
      check("addr_hold", hold_bad, 0);
      install(a);
    end
    check("busy_end", bif.busywait, 1'b0);
    check("instruction", bif.instruction, exp_word(a));
  endtask

  task automatic run_fetch(input logic [9:0] a, input int unsigned l);
    lat = l;
    @(posedge CLK); #1;
    bif.address = a;
    collect(a);
  endtask

  // Step negedges until a condition holds: 0 mem_read low, 1 mem_read high, 2 busywait low.
  task automatic step_until(input int sel);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(negedge CLK);
      n++;
      case (sel)
        0:       done = !bif.mem_read;
        1:       done = bif.mem_read;
        default: done = !bif.busywait;
      endcase
    end
    if (!done) check("wait_timeout", n, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a;
    RESET = 1'b1;
    bif.address = '0;
    lat = 4;
    for (int i = 0; i < 64; i++)
      mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0] = 128'h33333333_22222222_11111111_00000000;
    clear_model();

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", bif.busywait, 1'b0);
    check("reset_instr", bif.instruction, 32'h0);
    check("reset_mem_read", bif.mem_read, 1'b0);

    // Cold miss straight out of reset, 5-cycle memory access.
    @(posedge CLK); #1;
    RESET = 1'b0;
    lat = 4;
    bif.address = 10'h000;
    collect(10'h000);

    run_fetch(10'h004, 2);
    run_fetch(10'h008, 2);
    run_fetch(10'h00C, 2);

    // Conflict on set 0.
    run_fetch(10'h080, 3);
    run_fetch(10'h000, 1);

    // Two sets that coexist.
    run_fetch(10'h010, 2);
    run_fetch(10'h070, 5);
    for (int i = 0; i < 4; i++) begin
      run_fetch(10'h014, 1);
      run_fetch(10'h07C, 1);
    end

    // Address moves while the refill is in flight.
    lat = 3;
    @(posedge CLK); #1;
    bif.address = 10'h020;
    @(posedge CLK); #1;
    bif.address = 10'h040;
    @(negedge CLK);
    check("mid_mem_read", bif.mem_read, 1'b1);
    check("mid_mem_addr", bif.mem_address, 6'h02);
    step_until(0);
    install(10'h020);
    step_until(1);
    check("mid_refetch_addr", bif.mem_address, 6'h04);
    step_until(2);
    check("mid_instr", bif.instruction, exp_word(10'h040));
    install(10'h040);
    run_fetch(10'h028, 2);

    // Reset in the third busy cycle of a miss aborts the fill.
    lat = 5;
    @(posedge CLK); #1;
    bif.address = 10'h0A0;
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_busywait", bif.busywait, 1'b0);
    check("rst_mid_instr", bif.instruction, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    clear_model();
    collect(10'h0A0);
    run_fetch(10'h004, 2);

    // Random fetches, mostly within two tags so hits are frequent.
    for (int i = 0; i < 150; i++) begin
      a[9:7] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      a[6:4] = 3'($urandom_range(0, 7));
      a[3:2] = 2'($urandom_range(0, 3));
      a[1:0] = 2'($urandom_range(0, 3));
      run_fetch(a, $urandom_range(1, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
